// File: rtl/fib_seq_gen.sv
// Generalised Fibonacci term generator: t(0)=seed0, t(1)=seed1, t(k)=t(k-1)+t(k-2).
// Define FIB_SAT_EN to saturate terms at all-ones once overflow occurs; default build wraps.
module fib_seq_gen #(
  parameter int W  = 32,
  parameter int NW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          clr,
  input  logic [NW-1:0] n,
  input  logic [W-1:0]  seed0,
  input  logic [W-1:0]  seed1,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          ovf,
  output logic          term_valid,
  output logic [W-1:0]  term
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [NW-1:0]   r_cnt;
  logic            r_aovf;
  logic            r_bovf;
  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_result;
  logic            r_ovf;
  logic            r_term_valid;
  logic [W-1:0]    r_term;

  logic [W:0]      w_sum;
  logic            w_carry;
  logic [W-1:0]    w_b_nxt;
  logic            w_accept;
  logic            w_step;
  logic            w_finish;

  assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
  assign w_carry = w_sum[W];

`ifdef FIB_SAT_EN
  assign w_b_nxt = (w_carry | r_aovf | r_bovf) ? {W{1'b1}} : w_sum[W-1:0];
`else
  assign w_b_nxt = w_sum[W-1:0];
`endif

  // clr outranks start in IDLE and aborts RUN without touching result/ovf.
  assign w_accept = (r_state == S_IDLE) && start && !clr;
  assign w_step   = (r_state == S_RUN) && !clr && (r_cnt != '0);
  assign w_finish = (r_state == S_RUN) && !clr && (r_cnt == '0);

  always_comb begin
    // NOTE: default assigned first so no path leaves the variable unassigned, which would infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_RUN;
      S_RUN: begin
        if (clr)                  w_state_nxt = S_IDLE;
        else if (r_cnt == '0)     w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every state register is cleared by the async reset; there is no memory array here to exempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_aovf       <= 1'b0;
      r_bovf       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= '0;
      r_ovf        <= 1'b0;
      r_term_valid <= 1'b0;
      r_term       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values (a<=b, b<=a+b swap correctly).
      r_state      <= w_state_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_DONE);
      r_term_valid <= w_step;

      if (w_accept) begin
        r_a    <= seed0;
        r_b    <= seed1;
        r_cnt  <= n;
        r_aovf <= 1'b0;
        r_bovf <= 1'b0;
      end

      if (w_step) begin
        r_a    <= r_b;
        r_b    <= w_b_nxt;
        r_cnt  <= r_cnt - 1'b1;
        r_term <= r_a;
        r_aovf <= r_bovf;
        r_bovf <= w_carry | r_aovf | r_bovf;
      end

      if (w_finish) begin
        r_result <= r_a;
        r_ovf    <= r_aovf;
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign ovf        = r_ovf;
  assign term_valid = r_term_valid;
  assign term       = r_term;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed bench for fib_seq_gen: a W=32 and a W=8 instance share control inputs.
module tb_fib_seq_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic [5:0]  n = '0;
  logic [31:0] s0_32 = '0;
  logic [31:0] s1_32 = '0;

  logic        busy32, done32, ovf32, tv32;
  logic [31:0] res32, term32;
  logic        busy8, done8, ovf8, tv8;
  logic [7:0]  res8, term8;

  logic        sel8 = 1'b0;
  logic        o_busy, o_done, o_ovf, o_tv;
  logic [31:0] o_res, o_term;

  int n_checks = 0;
  int n_fail   = 0;

  int fib_t[16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};
  int luc_t[16] = '{2, 1, 3, 4, 7, 11, 18, 29, 47, 76, 123, 199, 322, 521, 843, 1364};

  always #5 clk = ~clk;

  fib_seq_gen #(.W(32), .NW(6)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .n(n),
    .seed0(s0_32), .seed1(s1_32),
    .busy(busy32), .done(done32), .result(res32), .ovf(ovf32),
    .term_valid(tv32), .term(term32)
  );

  fib_seq_gen #(.W(8), .NW(6)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .n(n),
    .seed0(s0_32[7:0]), .seed1(s1_32[7:0]),
    .busy(busy8), .done(done8), .result(res8), .ovf(ovf8),
    .term_valid(tv8), .term(term8)
  );

  assign o_busy = sel8 ? busy8 : busy32;
  assign o_done = sel8 ? done8 : done32;
  assign o_ovf  = sel8 ? ovf8  : ovf32;
  assign o_tv   = sel8 ? tv8   : tv32;
  assign o_res  = sel8 ? {24'd0, res8}  : res32;
  assign o_term = sel8 ? {24'd0, term8} : term32;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Launch one computation and follow it to done, checking the term stream on the way.
  task automatic run_seq(input string tag, input bit use8, input logic [31:0] s0,
                         input logic [31:0] s1, input int nn, input bit luc,
                         input logic [31:0] exp_res, input logic exp_ovf, input int glitch);
    int tcount    = 0;
    int done_edge = -1;
    sel8 = use8;
    @(negedge clk);
    s0_32 = s0; s1_32 = s1; n = 6'(nn); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy_run"}, {31'd0, o_busy}, 32'd1);
    for (int e = 1; e <= 100 && done_edge < 0; e++) begin
      @(negedge clk);
      if (glitch > 0 && e == glitch) begin
        start = 1'b1; n = 6'd3; s0_32 = 32'd9; s1_32 = 32'd9;
      end else begin
        start = 1'b0;
      end
      if (o_tv) begin
        if (tcount < 16)
          check($sformatf("%s.term%0d", tag, tcount), o_term,
                luc ? 32'(luc_t[tcount]) : 32'(fib_t[tcount]));
        tcount++;
      end
      if (o_done) done_edge = e;
    end
    start = 1'b0;
    check({tag, ".done_edge"}, 32'(done_edge), 32'(nn + 1));
    check({tag, ".term_count"}, 32'(tcount), 32'(nn));
    check({tag, ".result"}, o_res, exp_res);
    check({tag, ".ovf"}, {31'd0, o_ovf}, {31'd0, exp_ovf});
    @(negedge clk);
    check({tag, ".done_pulse"}, {31'd0, o_done}, 32'd0);
    check({tag, ".busy_idle"}, {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    int done_seen;

    // Reset state
    #12;
    check("rst.busy", {31'd0, busy32}, 32'd0);
    check("rst.done", {31'd0, done32}, 32'd0);
    check("rst.result", res32, 32'd0);
    check("rst.ovf", {31'd0, ovf32}, 32'd0);
    check("rst.term_valid", {31'd0, tv32}, 32'd0);
    check("rst.term", term32, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_seq("fib10", 1'b0, 32'd0, 32'd1, 10, 1'b0, 32'd55, 1'b0, 0);
    run_seq("lucas5", 1'b0, 32'd2, 32'd1, 5, 1'b1, 32'd11, 1'b0, 0);
    run_seq("w8_n13", 1'b1, 32'd0, 32'd1, 13, 1'b0, 32'd233, 1'b0, 0);
`ifdef FIB_SAT_EN
    run_seq("w8_n14", 1'b1, 32'd0, 32'd1, 14, 1'b0, 32'd255, 1'b1, 0);
`else
    run_seq("w8_n14", 1'b1, 32'd0, 32'd1, 14, 1'b0, 32'd121, 1'b1, 0);
`endif
    run_seq("n0", 1'b0, 32'd5, 32'd7, 0, 1'b0, 32'd5, 1'b0, 0);
    run_seq("restart_ign", 1'b0, 32'd0, 32'd1, 10, 1'b0, 32'd55, 1'b0, 3);

    // clr once cnt has counted down to 3 (after the 5th RUN edge of n=8)
    sel8 = 1'b0;
    @(negedge clk);
    s0_32 = 32'd2; s1_32 = 32'd1; n = 6'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr.busy", {31'd0, busy32}, 32'd0);
    check("clr.term_valid", {31'd0, tv32}, 32'd0);
    done_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done32) done_seen++;
    end
    check("clr.no_done", 32'(done_seen), 32'd0);
    check("clr.result_kept", res32, 32'd55);

    // clr and start together in IDLE: start is dropped
    @(negedge clk);
    s0_32 = 32'd1; s1_32 = 32'd1; n = 6'd2; start = 1'b1; clr = 1'b1;
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    check("clr_start.busy", {31'd0, busy32}, 32'd0);
    done_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done32) done_seen++;
    end
    check("clr_start.no_done", 32'(done_seen), 32'd0);

    // Reset in the middle of RUN
    @(negedge clk);
    s0_32 = 32'd0; s1_32 = 32'd1; n = 6'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.busy", {31'd0, busy32}, 32'd0);
    check("mid_rst.result", res32, 32'd0);
    check("mid_rst.term_valid", {31'd0, tv32}, 32'd0);
    check("mid_rst.term", term32, 32'd0);
    check("mid_rst.ovf", {31'd0, ovf32}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done32 || busy32) done_seen++;
    end
    check("mid_rst.no_done", 32'(done_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
